serial_adder: RTL and testbench

//   Bit-serial N-bit adder built around a single full-adder cell and a carry flip-flop.

---
 rtl/serial_adder_pkg.sv | 17 +
 rtl/serial_adder_if.sv | 27 ++
 rtl/serial_adder_fa_cell.sv | 15 +
 rtl/serial_adder.sv | 99 +++++++++
 tb/tb_serial_adder.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding, default width
// and the majority function used for the per-bit carry.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle of the bit-serial adder; master drives operands and
// start, slave (the adder) returns busy/done and the registered result.
interface serial_adder_if
    import serial_adder_pkg::*;
    #(parameter int WIDTH = DEFAULT_WIDTH)
    ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );

endinterface

// File: rtl/serial_adder_fa_cell.sv
// Single combinational full-adder cell; the serial adder reuses it once per bit.
module fa_cell
    import serial_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = maj3(a, b, cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB first,
// result and carry-out published together with a one-cycle done pulse.
module serial_adder
    import serial_adder_pkg::*;
    #(parameter int WIDTH = DEFAULT_WIDTH)
(
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic [WIDTH-1:0] sum_nxt;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;
    logic             s;
    logic             c;

    fa_cell u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .sum  (s),
        .cout (c)
    );

    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    assign sum_nxt = (sum_sr >> 1) | (WIDTH'(s) << (WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            sum_q  <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_sr   <= bus.a;
                        b_sr   <= bus.b;
                        carry  <= bus.cin;
                        cnt    <= '0;
                        state  <= S_SHIFT;
                        busy_q <= 1'b1;
                    end else begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    sum_sr <= sum_nxt;
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    carry  <= c;
                    if (cnt == LAST) begin
                        // Final bit: publish the whole result at once, never a partial one.
                        cnt    <= '0;
                        state  <= S_DONE;
                        sum_q  <= sum_nxt;
                        cout_q <= c;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: transaction-level timing/arithmetic model
// for the WIDTH=8 instance plus an exhaustive sweep of a WIDTH=3 instance.
module tb_serial_adder;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    logic cmp_en = 1'b0;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(W)) bus ();
    serial_adder_if #(.WIDTH(3)) bus3 ();

    serial_adder #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    serial_adder #(.WIDTH(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: an accepted add finishes exactly W edges later with a+b+cin.
    int         m_left = 0;
    logic [8:0] m_pend = '0;
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;
    logic [7:0] m_sum  = '0;
    logic       m_cout = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0;
            m_busy = 1'b0;
            m_done = 1'b0;
            m_sum  = '0;
            m_cout = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1'b1;
                    {m_cout, m_sum} = m_pend;
                end
            end else if (bus.start) begin
                m_left = W;
                m_pend = {1'b0, bus.a} + {1'b0, bus.b} + {8'd0, bus.cin};
            end
            m_busy = (m_left > 0);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", 32'(bus.busy), 32'(m_busy));
            chk("done", 32'(bus.done), 32'(m_done));
            chk("sum",  32'(bus.sum),  32'(m_sum));
            chk("cout", 32'(bus.cout), 32'(m_cout));
        end
    end

    // Drive one start pulse; returns on the falling edge after the sampling edge.
    task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic c);
        @(negedge clk);
        bus.a = a; bus.b = b; bus.cin = c; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Counts edges until done is seen; a missing done shows up as n==40.
    task automatic wait_done(output int n, output int nbusy);
        n = 0;
        nbusy = bus.busy ? 1 : 0;
        do begin
            @(negedge clk);
            n++;
            if (bus.busy) nbusy++;
        end while (!bus.done && n < 40);
    endtask

    task automatic run3(input logic [2:0] a, input logic [2:0] b, input logic c);
        int n;
        @(negedge clk);
        bus3.a = a; bus3.b = b; bus3.cin = c; bus3.start = 1'b1;
        @(negedge clk);
        bus3.start = 1'b0;
        n = 0;
        while (!bus3.done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("w3_latency", 32'(n), 32'd3);
        chk("w3_result", 32'({bus3.cout, bus3.sum}), 32'(int'(a) + int'(b) + int'(c)));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, nb, prev;
        bus.start = 0; bus.a = '0; bus.b = '0; bus.cin = 0;
        bus3.start = 0; bus3.a = '0; bus3.b = '0; bus3.cin = 0;
        repeat (2) @(posedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_sum",  32'(bus.sum),  0);
        chk("rst_cout", 32'(bus.cout), 0);
        rst_n = 1'b1;

        // Basic add, latency and busy length
        launch(8'h5A, 8'h3C, 1'b0);
        wait_done(n, nb);
        chk("t1_latency", 32'(n), 32'd8);
        chk("t1_busy_cycles", 32'(nb), 32'd8);
        chk("t1_sum", 32'(bus.sum), 32'h96);
        chk("t1_cout", 32'(bus.cout), 0);
        chk("t1_model_sum", 32'(m_sum), 32'h96);

        // Overflow corners
        launch(8'hFF, 8'h01, 1'b0);
        wait_done(n, nb);
        chk("t2a_sum", 32'(bus.sum), 32'h00);
        chk("t2a_cout", 32'(bus.cout), 1);
        launch(8'hFF, 8'hFF, 1'b1);
        wait_done(n, nb);
        chk("t2b_sum", 32'(bus.sum), 32'hFF);
        chk("t2b_cout", 32'(bus.cout), 1);
        chk("t2b_model", 32'({m_cout, m_sum}), 32'h1FF);

        // Start during SHIFT must be ignored
        launch(8'h10, 8'h20, 1'b0);
        repeat (1) @(negedge clk);
        bus.a = 8'hAA; bus.b = 8'h55; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(n, nb);
        chk("t3_latency", 32'(n), 32'd6);
        chk("t3_sum", 32'(bus.sum), 32'h30);
        chk("t3_cout", 32'(bus.cout), 0);
        @(negedge clk);
        chk("t3_busy_after", 32'(bus.busy), 0);
        chk("t3_sum_held", 32'(bus.sum), 32'h30);

        // Async reset mid-add
        launch(8'h80, 8'h80, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_busy", 32'(bus.busy), 0);
        chk("t4_done", 32'(bus.done), 0);
        chk("t4_sum", 32'(bus.sum), 0);
        chk("t4_cout", 32'(bus.cout), 0);
        repeat (10) begin
            @(negedge clk);
            chk("t4_no_done", 32'(bus.done), 0);
        end
        #2 rst_n = 1'b1;
        launch(8'h01, 8'h01, 1'b0);
        wait_done(n, nb);
        chk("t4_sum_after", 32'(bus.sum), 32'h02);

        // Back-to-back with start held high
        @(negedge clk);
        bus.a = 8'($urandom); bus.b = 8'($urandom); bus.cin = 1'($urandom); bus.start = 1'b1;
        @(negedge clk);
        prev = 0;
        for (int i = 0; i < 5; i++) begin
            wait_done(n, nb);
            chk("t5_interval", 32'(n), (i == 0) ? 32'd8 : 32'd9);
            bus.a = 8'($urandom); bus.b = 8'($urandom); bus.cin = 1'($urandom);
            prev++;
        end
        chk("t5_results", 32'(prev), 32'd5);
        bus.start = 1'b0;
        repeat (12) @(negedge clk);

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            bus.start = ($urandom_range(0, 3) == 0);
            bus.a = 8'($urandom);
            bus.b = 8'($urandom);
            bus.cin = 1'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
        repeat (12) @(negedge clk);

        // WIDTH=3 exhaustive sweep
        for (int a = 0; a < 8; a++)
            for (int b = 0; b < 8; b++)
                for (int c = 0; c < 2; c++)
                    run3(3'(a), 3'(b), 1'(c));

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
